// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding, slice width
// and the single-bit full-adder equation used by the 4-bit slice.
package nibble_serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

  // Full adder: returns {carry_out, sum}
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry slice built from per-bit full adders.
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] carry_s;

  // Ripple the carry through the four bit positions
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    carry_s[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      {carry_s[i+1], sum[i]} = full_add(a[i], b[i], carry_s[i]);
    end
    cout = carry_s[SLICE_W];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit slice processes a nibble per cycle, the
// slice carry is kept in a register between cycles. Valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH-1:0]   out_sum_r;
  logic               out_cout_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic               busy_r;

  logic [SLICE_W-1:0] slice_sum_s;
  logic               slice_cout_s;
  logic [WIDTH-1:0]   sum_nxt_s;
  logic               accept_s;
  logic               last_s;

  nibble_add4 u_slice (
    .a    (a_r[SLICE_W-1:0]),
    .b    (b_r[SLICE_W-1:0]),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // The partial-sum shift register only needs the nibbles that survive the next shift;
  // the fresh slice result always enters at the top.
  if (NIB == 1) begin : g_one_nibble
    assign sum_nxt_s = slice_sum_s;
  end else begin : g_multi_nibble
    logic [WIDTH-SLICE_W-1:0] acc_r;

    // Partial sum accumulates nibble results while running
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_r <= '0;
      end else if (state_r == RUN) begin
        acc_r <= sum_nxt_s[WIDTH-1:SLICE_W];
      end else begin
        acc_r <= acc_r;
      end
    end

    assign sum_nxt_s = {slice_sum_s, acc_r};
  end

  assign accept_s = (state_r == IDLE) && in_valid && in_ready_r;
  assign last_s   = (cnt_r == LAST);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, nibble shifting, inter-cycle carry and result latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      carry_r    <= 1'b0;
      cnt_r      <= '0;
      out_sum_r  <= '0;
      out_cout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= in_a;
            b_r     <= in_b;
            carry_r <= in_cin;
            cnt_r   <= '0;
          end else begin
            a_r     <= a_r;
          end
        end
        RUN: begin
          a_r     <= a_r >> SLICE_W;
          b_r     <= b_r >> SLICE_W;
          carry_r <= slice_cout_s;
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            out_sum_r  <= sum_nxt_s;
            out_cout_r <= slice_cout_s;
          end else begin
            out_sum_r  <= out_sum_r;
          end
        end
        default: begin
          a_r <= a_r;
        end
      endcase
    end
  end

  // Handshake/status flags registered from the next state; in_ready stays low
  // until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
module tb_nibble_serial_adder;

  logic        clk;
  logic        rst_n;

  logic        iv16, ir16, cin16, or16, ov16, c16, busy16;
  logic [15:0] a16, b16, s16;

  logic        iv4, ir4, cin4, or4, ov4, c4, busy4;
  logic [3:0]  a4, b4, s4;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv16), .in_ready(ir16), .in_a(a16), .in_b(b16), .in_cin(cin16),
    .out_valid(ov16), .out_ready(or16), .out_sum(s16), .out_cout(c16), .busy(busy16)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv4), .in_ready(ir4), .in_a(a4), .in_b(b4), .in_cin(cin4),
    .out_valid(ov4), .out_ready(or4), .out_sum(s4), .out_cout(c4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout,sum} = A + B + cin at width w
  function automatic logic [32:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    longint unsigned m, full;
    m    = (64'd1 << w) - 64'd1;
    full = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
    model = {(full >> w) != 64'd0 ? 1'b1 : 1'b0, 32'(full & m)};
  endfunction

  task automatic launch16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n = 0;
    while (!ir16 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_launch", ir16, 1'b1);
    iv16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
  endtask

  // Edges counted include the accepting edge itself
  task automatic wait_done16(output int edges);
    edges = 1;
    while (!ov16 && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
  endtask

  task automatic pop16();
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
  endtask

  task automatic directed16(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic cin, input logic [15:0] esum, input logic ecout);
    int edges;
    launch16(a, b, cin);
    wait_done16(edges);
    check({tag, "_latency"}, edges, 5);
    check({tag, "_sum"}, s16, esum);
    check({tag, "_cout"}, c16, ecout);
    pop16();
  endtask

  task automatic drive(input int which, input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic ordy);
    if (which == 16) begin
      iv16 = iv; a16 = a; b16 = b; cin16 = cin; or16 = ordy;
    end else begin
      iv4 = iv; a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; or4 = ordy;
    end
  endtask

  task automatic rand_run(input int which, input int nops);
    logic [31:0] q_sum[$];
    logic        q_cout[$];
    logic [32:0] r;
    logic [15:0] a, b;
    logic        cin, have, ivl, ordy, ov, ir, c;
    logic [31:0] s;
    int issued = 0, got = 0, cyc = 0;
    have = 1'b0; a = 16'd0; b = 16'd0; cin = 1'b0;
    while (got < nops && cyc < 30000) begin
      if (!have && issued < nops) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); have = 1'b1;
      end
      ivl  = have && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      drive(which, ivl, a, b, cin, ordy);
      ov = (which == 16) ? ov16 : ov4;
      ir = (which == 16) ? ir16 : ir4;
      s  = (which == 16) ? {16'd0, s16} : {28'd0, s4};
      c  = (which == 16) ? c16 : c4;
      if (ov && ordy) begin
        if (q_sum.size() == 0) begin
          check($sformatf("w%0d_unexpected_result", which), q_sum.size(), 1);
        end else begin
          check($sformatf("w%0d_rand_sum", which), s, q_sum.pop_front());
          check($sformatf("w%0d_rand_cout", which), c, q_cout.pop_front());
          got++;
        end
      end
      if (ivl && ir) begin
        r = model(which, a, b, cin);
        q_sum.push_back(r[31:0]);
        q_cout.push_back(r[32]);
        issued++;
        have = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive(which, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    check($sformatf("w%0d_results_received", which), got, nops);
    check($sformatf("w%0d_results_pending", which), q_sum.size(), 0);
  endtask

  initial begin
    logic [15:0] held;
    int edges;
    rst_n = 1'b1;
    iv16 = 1'b0; a16 = 16'd0; b16 = 16'd0; cin16 = 1'b0; or16 = 1'b0;
    iv4 = 1'b0; a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; or4 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", ov16, 1'b0);
    check("rst_out_sum", s16, 16'd0);
    check("rst_out_cout", c16, 1'b0);
    check("rst_busy", busy16, 1'b0);
    check("rst_w4_out_valid", ov4, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", ir16, 1'b1);
    check("w4_in_ready_after_reset", ir4, 1'b1);

    directed16("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    directed16("t2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    directed16("t3a", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    directed16("t3b", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);

    // Backpressure: result held in DONE while in_valid pulses with other data
    launch16(16'h00F0, 16'h0F10, 1'b0);
    wait_done16(edges);
    check("bp_latency", edges, 5);
    held = 16'h1000;
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", ov16, 1'b1);
      check("bp_sum", s16, held);
      check("bp_cout", c16, 1'b0);
      check("bp_in_ready", ir16, 1'b0);
      iv16 = 1'(i); a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'b1;
      @(posedge clk); #1;
    end
    iv16 = 1'b1; or16 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", ov16, 1'b0);
    check("bp_release_busy", busy16, 1'b0);
    check("bp_release_sum", s16, held);
    check("bp_release_in_ready", ir16, 1'b1);
    iv16 = 1'b0; or16 = 1'b0;
    @(posedge clk); #1;
    check("bp_no_overlap_busy", busy16, 1'b0);
    check("bp_sum_kept", s16, held);

    // Reset during RUN at cnt=2 discards the operation
    launch16(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", ov16, 1'b0);
    check("midrun_rst_busy", busy16, 1'b0);
    check("midrun_rst_sum", s16, 16'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrun_in_ready", ir16, 1'b1);
    check("midrun_busy_idle", busy16, 1'b0);
    directed16("t5", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    rand_run(16, 300);
    rand_run(4, 200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
